// File: rtl/mem_pkg.sv
// Shared types and default geometry for the line memory responder.
package mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRdBurst,
    StWrBurst,
    StDone
  } state_e;

  localparam int unsigned WORDS_PER_LINE_DEF = 16;
  localparam int unsigned MEM_LINES_DEF      = 1024;
  localparam int unsigned WORD_OFS_W         = $clog2(WORDS_PER_LINE_DEF);
  localparam int unsigned LINE_IDX_W         = $clog2(MEM_LINES_DEF);

endpackage

// File: rtl/line_mem_array.sv
// Backing store: one write port, one read port with a registered output.
module line_mem_array #(
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_resp.sv
// Memory-side responder for cache line fills and writebacks.
// Optional range check enabled by defining LINE_MEM_RANGE_CHK_EN.
module line_mem_resp
  import mem_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int unsigned MEM_LINES      = MEM_LINES_DEF,
  parameter int unsigned ACCESS_LAT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] wr_data,
  input  logic        wr_data_vld,
  output logic        wr_data_rdy,
  output logic [31:0] rd_data,
  output logic        rd_data_vld,
  output logic        rd_last,
  output logic        done,
  output logic        err
);

  localparam int unsigned OFS_W   = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W   = $clog2(MEM_LINES);
  localparam int unsigned SHIFT_W = OFS_W + 2;
  localparam int unsigned WC_W    = OFS_W + 1;
  localparam int unsigned CNT_W   = $clog2(ACCESS_LAT + 1);
  localparam int unsigned ADDR_W  = IDX_W + OFS_W;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WC_W-1:0]    word_q;
  logic [IDX_W-1:0]   line_q;
  logic               wr_q;
  logic               req_rdy_q;
  logic               wr_data_rdy_q;
  logic               rd_data_vld_q;
  logic               rd_last_q;
  logic               done_q;
  logic               oor_q;

  logic               req_acc;
  logic               wr_acc;
  logic               rd_re;
  logic [ADDR_W-1:0]  arr_addr;
  logic               unused_addr;

  assign unused_addr = ^{req_addr[SHIFT_W-1:0], req_addr[31:SHIFT_W+IDX_W]};

  always_comb begin
    req_acc  = (state_q == StIdle) && req_vld && req_rdy_q;
    wr_acc   = wr_data_rdy_q && wr_data_vld;
    // Read one word ahead: word 0 goes out during the last wait cycle.
    rd_re    = ((state_q == StWait) && (cnt_q == CNT_W'(1)) && !wr_q && !oor_q) ||
               ((state_q == StRdBurst) && !word_q[OFS_W]);
    arr_addr = {line_q, word_q[OFS_W-1:0]};
  end

`ifdef LINE_MEM_RANGE_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          oor_q <= 1'b0;
    else if (req_acc) oor_q <= (req_addr >> SHIFT_W) >= 32'(MEM_LINES);
  end
`else
  assign oor_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      word_q        <= '0;
      line_q        <= '0;
      wr_q          <= 1'b0;
      req_rdy_q     <= 1'b0;
      wr_data_rdy_q <= 1'b0;
      rd_data_vld_q <= 1'b0;
      rd_last_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      rd_data_vld_q <= rd_re;
      rd_last_q     <= rd_re && (word_q == WC_W'(WORDS_PER_LINE - 1));
      if (state_q == StDone)       word_q <= '0;
      else if (rd_re || wr_acc)    word_q <= word_q + WC_W'(1);

      unique case (state_q)
        StIdle: begin
          if (req_acc) begin
            line_q    <= req_addr[SHIFT_W +: IDX_W];
            wr_q      <= req_wr;
            cnt_q     <= CNT_W'(ACCESS_LAT);
            req_rdy_q <= 1'b0;
            state_q   <= StWait;
          end else begin
            req_rdy_q <= 1'b1;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (oor_q) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (wr_q) begin
              wr_data_rdy_q <= 1'b1;
              state_q       <= StWrBurst;
            end else begin
              state_q <= StRdBurst;
            end
          end
        end
        StRdBurst: begin
          if (rd_last_q) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StWrBurst: begin
          if (wr_acc && (word_q == WC_W'(WORDS_PER_LINE - 1))) begin
            wr_data_rdy_q <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= StDone;
          end
        end
        StDone: begin
          req_rdy_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  line_mem_array #(
    .DEPTH  (MEM_LINES * WORDS_PER_LINE),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (arr_addr),
    .wdata (wr_data),
    .re    (rd_re),
    .raddr (arr_addr),
    .rdata (rd_data)
  );

  assign req_rdy     = req_rdy_q;
  assign wr_data_rdy = wr_data_rdy_q;
  assign rd_data_vld = rd_data_vld_q;
  assign rd_last     = rd_last_q;
  assign done        = done_q;
  assign err         = done_q && oor_q;

endmodule

// File: tb/tb_line_mem_resp.sv
// Directed bench for line_mem_resp: fills, writebacks, gaps, reset abort, aliasing.
module tb_line_mem_resp;

  localparam int LAT = 4;
  localparam int WPL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld, req_rdy, req_wr;
  logic [31:0] req_addr, wr_data, rd_data;
  logic        wr_data_vld, wr_data_rdy, rd_data_vld, rd_last, done, err;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] model [0:3][0:WPL-1];

  line_mem_resp #(
    .WORDS_PER_LINE (WPL),
    .MEM_LINES      (1024),
    .ACCESS_LAT     (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .wr_data     (wr_data),
    .wr_data_vld (wr_data_vld),
    .wr_data_rdy (wr_data_rdy),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .rd_last     (rd_last),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_rdy();
    int t = 0;
    while (!req_rdy && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("accept", {31'd0, req_rdy}, 32'd1);
  endtask

  task automatic write_line(input logic [31:0] addr, input int line, input logic [31:0] base,
                            input bit gaps, input bit abort);
    int n = 0;
    int guard = 0;
    bit ph = 1'b0;
    bit aborted = 1'b0;
    req_wr = 1'b1; req_addr = addr; req_vld = 1'b1;
    wait_rdy();
    // Junk offered during the latency window must be ignored.
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      req_vld = 1'b0;
      wr_data_vld = 1'b1;
      wr_data = 32'hDEAD_0000 | k;
      check("wr_rdy_wait", {31'd0, wr_data_rdy}, 32'd0);
    end
    while (n < WPL && guard < 4 * WPL) begin
      @(negedge clk);
      guard++;
      check("wr_rdy", {31'd0, wr_data_rdy}, 32'd1);
      check("wr_nodone", {31'd0, done}, 32'd0);
      if (abort && n == 7) begin
        aborted = 1'b1;
        rst = 1'b1;
        wr_data_vld = 1'b0;
        break;
      end
      if (gaps && ph) begin
        wr_data_vld = 1'b0;
      end else begin
        wr_data_vld = 1'b1;
        wr_data = base + n;
        model[line][n] = base + n;
        n++;
      end
      if (gaps) ph = ~ph;
    end
    if (aborted) begin
      #1;
      check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
      check("rst_wr_rdy", {31'd0, wr_data_rdy}, 32'd0);
      check("rst_rd_vld", {31'd0, rd_data_vld}, 32'd0);
      check("rst_rd_last", {31'd0, rd_last}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      repeat (2) begin
        @(negedge clk);
        check("rst_nodone", {31'd0, done}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("rst_rdy_after", {31'd0, req_rdy}, 32'd1);
      check("rst_nodone_after", {31'd0, done}, 32'd0);
    end else begin
      check("wr_count", n, WPL);
      @(negedge clk);
      wr_data_vld = 1'b0;
      check("wr_done", {31'd0, done}, 32'd1);
      check("wr_rdy_drop", {31'd0, wr_data_rdy}, 32'd0);
      @(negedge clk);
      check("wr_done_pulse", {31'd0, done}, 32'd0);
      check("wr_req_rdy", {31'd0, req_rdy}, 32'd1);
    end
  endtask

  task automatic read_line(input logic [31:0] addr, input int line, input bit hold,
                           input bit oor);
    int dn;
    dn = oor ? LAT + 1 : LAT + WPL + 1;
    req_wr = 1'b0; req_addr = addr; req_vld = 1'b1;
    wait_rdy();
    for (int k = 1; k <= dn + 1; k++) begin
      bit ev;
      @(negedge clk);
      if (!hold) req_vld = 1'b0;
      ev = !oor && k >= LAT + 1 && k <= LAT + WPL;
      check("rd_vld", {31'd0, rd_data_vld}, {31'd0, ev});
      check("rd_last", {31'd0, rd_last}, {31'd0, ev && k == LAT + WPL});
      if (ev) check("rd_data", rd_data, model[line][k-LAT-1]);
      check("rd_done", {31'd0, done}, {31'd0, k == dn});
      check("rd_err", {31'd0, err}, {31'd0, oor && k == dn});
      check("rd_req_rdy", {31'd0, req_rdy}, {31'd0, k == dn + 1});
    end
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    wr_data = '0; wr_data_vld = 1'b0;
    #2;
    check("reset_req_rdy", {31'd0, req_rdy}, 32'd0);
    check("reset_wr_rdy", {31'd0, wr_data_rdy}, 32'd0);
    check("reset_rd_vld", {31'd0, rd_data_vld}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_rdy", {31'd0, req_rdy}, 32'd1);

    // Line 1: plain write, then read with non-zero offset bits.
    write_line(32'h0000_0040, 1, 32'hA000_0000, 1'b0, 1'b0);
    read_line(32'h0000_0044, 1, 1'b0, 1'b0);

    // Line 2: writeback with alternating gaps.
    write_line(32'h0000_0080, 2, 32'hB000_0000, 1'b1, 1'b0);
    read_line(32'h0000_0080, 2, 1'b0, 1'b0);

    // Back-to-back reads with req_vld held high.
    read_line(32'h0000_0044, 1, 1'b1, 1'b0);
    read_line(32'h0000_0080, 2, 1'b0, 1'b0);

    // Line 3: old contents, then a writeback aborted by reset at the 8th beat.
    write_line(32'h0000_00C0, 3, 32'h3000_0000, 1'b0, 1'b0);
    write_line(32'h0000_00C0, 3, 32'h3F00_0000, 1'b0, 1'b1);
    read_line(32'h0000_00C0, 3, 1'b0, 1'b0);

    // Line 0, then the first address past the array.
    write_line(32'h0000_0000, 0, 32'hC000_0000, 1'b0, 1'b0);
`ifdef LINE_MEM_RANGE_CHK_EN
    read_line(32'h0001_0000, 0, 1'b0, 1'b1);
`else
    read_line(32'h0001_0000, 0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
